// File: rtl/rda_pkg.sv
// Shared types and helpers for the restoring divider.
package rda_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rda_step.sv
// One restoring-division iteration: shift {A,Q}, trial-subtract M, restore or keep.
module rda_step #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_q,
  input  logic [N:0]   i_m,
  output logic [N:0]   o_a,
  output logic [N-1:0] o_q
);

  logic [N:0]   w_a_sh;
  logic [N-1:0] w_q_sh;
  logic [N:0]   w_t;

  // A never exceeds M-1 between iterations, so its top bit is always clear
  // and only the low N bits feed the shift.
  assign w_a_sh = {i_a, i_q[N-1]};
  assign w_q_sh = {i_q[N-2:0], 1'b0};
  assign w_t    = w_a_sh - i_m;

  always_comb begin
    o_a = w_a_sh;
    o_q = w_q_sh;
    if (!w_t[N]) begin
      o_a = w_t;
      o_q = {w_q_sh[N-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/rda.sv
// Sequential unsigned restoring divider: one quotient bit per clock after a start pulse.
//   state  | meaning
//   S_IDLE | waiting for start after reset
//   S_RUN  | iterating, count = iterations remaining
//   S_DONE | result held in regQ/regA until next start
module rda
  import rda_pkg::*;
#(
  parameter int N = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N-1:0]            dividendo,
  input  logic [N-1:0]            divisor,
  output logic [N-1:0]            regQ,
  output logic [N:0]              regA,
  output logic [cnt_width(N)-1:0] count
);

  localparam int CW = cnt_width(N);

  state_t        r_state;
  logic [N:0]    r_a;
  logic [N:0]    r_m;
  logic [N-1:0]  r_q;
  logic [CW-1:0] r_cnt;

  logic [N:0]    w_a_nxt;
  logic [N-1:0]  w_q_nxt;

  rda_step #(.N(N)) u_step (
    .i_a (r_a[N-1:0]),
    .i_q (r_q),
    .i_m (r_m),
    .o_a (w_a_nxt),
    .o_q (w_q_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= '0;
            r_q     <= dividendo;
            r_m     <= {1'b0, divisor};
            r_cnt   <= CW'(N);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign regQ  = r_q;
  assign regA  = r_a;
  assign count = r_cnt;

endmodule

// File: tb/tb_rda.sv
// Self-checking bench for rda (N=5): vector table, scoreboard queue, corner sequences.
module tb_rda;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic [N-1:0] regQ;
  logic [N:0]   regA;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] dd;
    logic [N-1:0] dv;
    logic [N-1:0] q;
    logic [N:0]   a;
  } vec_t;

  typedef struct {
    logic [N-1:0] q;
    logic [N:0]   a;
    string        nm;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[6];

  rda #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .regQ      (regQ),
    .regA      (regA),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
  endtask

  // Drive one start pulse, push expectation, wait out the fixed latency, pop and compare.
  task automatic run_div(input logic [N-1:0] dd, input logic [N-1:0] dv,
                         input logic [N-1:0] eq, input logic [N:0] ea,
                         input string nm, input bit full);
    exp_t e;
    @(negedge clk);
    dividendo = dd;
    divisor   = dv;
    start     = 1'b1;
    sb.push_back('{q: eq, a: ea, nm: nm});
    @(posedge clk); #1;
    if (full) chk({nm, " count@load"}, int'(count), N);
    @(negedge clk);
    start     = 1'b0;
    dividendo = ~dd;
    divisor   = ~dv;
    repeat (N) @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, " scoreboard empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.nm, " regQ"}, int'(regQ), int'(e.q));
      chk({e.nm, " regA"}, int'(regA), int'(e.a));
      if (full) chk({e.nm, " count"}, int'(count), 0);
    end
  endtask

  function automatic logic [N-1:0] mq(input int i, input int j);
    return (j == 0) ? N'(31) : N'(i / j);
  endfunction

  function automatic logic [N:0] ma(input int i, input int j);
    return (j == 0) ? (N+1)'(i) : (N+1)'(i % j);
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; dividendo = '0; divisor = '0;

    tbl[0] = '{dd: 5'd11, dv: 5'd5,  q: 5'd2,  a: 6'd1};
    tbl[1] = '{dd: 5'd13, dv: 5'd3,  q: 5'd4,  a: 6'd1};
    tbl[2] = '{dd: 5'd15, dv: 5'd15, q: 5'd1,  a: 6'd0};
    tbl[3] = '{dd: 5'd15, dv: 5'd1,  q: 5'd15, a: 6'd0};
    tbl[4] = '{dd: 5'd0,  dv: 5'd7,  q: 5'd0,  a: 6'd0};
    tbl[5] = '{dd: 5'd9,  dv: 5'd0,  q: 5'd31, a: 6'd9};

    repeat (2) @(posedge clk);
    #1;
    chk("reset regQ",  int'(regQ),  0);
    chk("reset regA",  int'(regA),  0);
    chk("reset count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors back to back, no reset between (DONE -> restart).
    for (int k = 0; k < 6; k++)
      run_div(tbl[k].dd, tbl[k].dv, tbl[k].q, tbl[k].a, $sformatf("vec%0d", k), 1'b1);

    // Result holds in DONE.
    repeat (4) @(posedge clk);
    #1;
    chk("hold regQ",  int'(regQ),  31);
    chk("hold regA",  int'(regA),  9);
    chk("hold count", int'(count), 0);

    // start during RUN is ignored.
    @(negedge clk);
    dividendo = 5'd29; divisor = 5'd4; start = 1'b1;
    @(negedge clk);
    dividendo = 5'd3; divisor = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    chk("ignore-start regQ", int'(regQ), 7);
    chk("ignore-start regA", int'(regA), 1);

    // Reset mid-run aborts.
    @(negedge clk);
    dividendo = 5'd31; divisor = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midrun count", int'(count), 4);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort regQ",  int'(regQ),  0);
    chk("abort regA",  int'(regA),  0);
    chk("abort count", int'(count), 0);
    @(negedge clk);
    rst = 1'b0;
    run_div(5'd31, 5'd2, 5'd15, 6'd1, "after-abort 31/2", 1'b1);

    // Exhaustive sweep with reset between runs.
    for (int i = 0; i < 32; i++) begin
      for (int j = 1; j < 32; j++) begin
        do_reset();
        run_div(N'(i), N'(j), mq(i, j), ma(i, j), $sformatf("sweep %0d/%0d", i, j), 1'b0);
      end
    end
    do_reset();
    run_div(5'd9, 5'd0, mq(9, 0), ma(9, 0), "div0 9/0", 1'b1);

    chk("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
